// File: rtl/iob_pfsm_timed_pkg.sv
// Shared encodings for the timed programmable FSM: control states, config
// table selectors and a width helper.
package iob_pfsm_timed_pkg;

    typedef enum logic [1:0] {
        CTRL_IDLE = 2'd0,
        CTRL_RUN  = 2'd1,
        CTRL_DONE = 2'd2
    } ctrl_e;

    localparam logic CFG_SEL_LUT   = 1'b0;
    localparam logic CFG_SEL_DWELL = 1'b1;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/iob_pfsm_timed_if.sv
// Config write port of the timed PFSM, driven by the CSR layer (master)
// and accepted by the FSM core (slave).
interface iob_pfsm_timed_if #(
    parameter int INPUT_W  = 2,
    parameter int STATE_W  = 3,
    parameter int OUTPUT_W = 8,
    parameter int CNT_W    = 16
);
    localparam int WDATA_W = iob_pfsm_timed_pkg::max_w(STATE_W + OUTPUT_W, CNT_W);

    logic                       cfg_valid_i;
    logic                       cfg_sel_i;
    logic [STATE_W+INPUT_W-1:0] cfg_addr_i;
    logic [WDATA_W-1:0]         cfg_wdata_i;
    logic                       cfg_ready_o;

    modport master (
        output cfg_valid_i, cfg_sel_i, cfg_addr_i, cfg_wdata_i,
        input  cfg_ready_o
    );

    modport slave (
        input  cfg_valid_i, cfg_sel_i, cfg_addr_i, cfg_wdata_i,
        output cfg_ready_o
    );
endinterface

// File: rtl/iob_pfsm_timed_dwell.sv
// Dwell timer: loadable down-counter with zero flag, plus a saturating
// event counter used to count FSM transitions.
module iob_pfsm_timed_dwell #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cke_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    input  logic             evt_clr_i,
    input  logic             evt_inc_i,
    output logic             zero_o,
    output logic [CNT_W-1:0] evt_cnt_o
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_evt;

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                r_cnt <= '0;
                r_evt <= '0;
            end else begin
                if (load_i) begin
                    r_cnt <= load_val_i;
                end else if (dec_i && (r_cnt != '0)) begin
                    r_cnt <= r_cnt - 1'b1;
                end
                if (evt_clr_i) begin
                    r_evt <= '0;
                end else if (evt_inc_i && (r_evt != '1)) begin
                    r_evt <= r_evt + 1'b1;
                end
            end
        end
    end

    assign zero_o    = (r_cnt == '0);
    assign evt_cnt_o = r_evt;

endmodule

// File: rtl/iob_pfsm_timed.sv
// Programmable FSM with software-loaded transition/output LUT, per-state
// minimum dwell, start/stop/done run control and a transition counter.
module iob_pfsm_timed
    import iob_pfsm_timed_pkg::*;
#(
    parameter int INPUT_W  = 2,
    parameter int STATE_W  = 3,
    parameter int OUTPUT_W = 8,
    parameter int CNT_W    = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cke_i,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic [INPUT_W-1:0]  input_i,
    iob_pfsm_timed_if.slave     cfg_if,
    output logic                busy_o,
    output logic                done_o,
    output logic [STATE_W-1:0]  state_o,
    output logic [OUTPUT_W-1:0] output_o,
    output logic [CNT_W-1:0]    trans_cnt_o
);
    localparam int LUT_W       = STATE_W + OUTPUT_W;
    localparam int ADDR_W      = STATE_W + INPUT_W;
    localparam int LUT_DEPTH   = 1 << ADDR_W;
    localparam int DWELL_DEPTH = 1 << STATE_W;
    localparam logic [STATE_W-1:0] HALT_STATE = '1;
    localparam logic [STATE_W-1:0] INIT_STATE = '0;

    ctrl_e               r_ctrl;
    logic [STATE_W-1:0]  r_state;
    logic [OUTPUT_W-1:0] r_out;
    logic                r_done;
    logic [LUT_W-1:0]    r_lut       [LUT_DEPTH];
    logic [CNT_W-1:0]    r_dwell_tab [DWELL_DEPTH];

    logic                w_cfg_ready;
    logic                w_cfg_we;
    logic [LUT_W-1:0]    w_lut_word;
    logic [STATE_W-1:0]  w_next_state;
    logic [OUTPUT_W-1:0] w_next_out;
    logic                w_running;
    logic                w_start;
    logic                w_trans;
    logic                w_dwell_zero;
    logic [CNT_W-1:0]    w_dwell_val;

    assign w_cfg_ready  = (r_ctrl != CTRL_RUN);
    assign w_cfg_we     = cfg_if.cfg_valid_i && w_cfg_ready;
    assign w_lut_word   = r_lut[{r_state, input_i}];
    assign w_next_state = w_lut_word[LUT_W-1:OUTPUT_W];
    assign w_next_out   = w_lut_word[OUTPUT_W-1:0];
    assign w_running    = (r_ctrl == CTRL_RUN);
    assign w_start      = !w_running && start_i && !stop_i;
    assign w_trans      = w_running && !stop_i && w_dwell_zero;
    // A start always enters state 0; a transition enters the LUT's next state.
    assign w_dwell_val  = w_start ? r_dwell_tab[INIT_STATE] : r_dwell_tab[w_next_state];

    // NOTE: the tables are cleared on reset so a fresh FSM never walks uninitialised entries.
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                for (int i = 0; i < LUT_DEPTH; i++) r_lut[i] <= '0;
                for (int i = 0; i < DWELL_DEPTH; i++) r_dwell_tab[i] <= '0;
            end else if (w_cfg_we) begin
                case (cfg_if.cfg_sel_i)
                    CFG_SEL_LUT:   r_lut[cfg_if.cfg_addr_i] <= cfg_if.cfg_wdata_i[LUT_W-1:0];
                    CFG_SEL_DWELL: r_dwell_tab[cfg_if.cfg_addr_i[STATE_W-1:0]] <=
                                       cfg_if.cfg_wdata_i[CNT_W-1:0];
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                r_ctrl  <= CTRL_IDLE;
                r_state <= INIT_STATE;
                r_out   <= '0;
                r_done  <= 1'b0;
            end else begin
                r_done <= 1'b0;
                case (r_ctrl)
                    CTRL_RUN: begin
                        if (stop_i) begin
                            r_ctrl  <= CTRL_IDLE;
                            r_state <= INIT_STATE;
                            r_out   <= '0;
                        end else if (w_dwell_zero) begin
                            r_state <= w_next_state;
                            r_out   <= w_next_out;
                            if (w_next_state == HALT_STATE) begin
                                r_ctrl <= CTRL_DONE;
                                r_done <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        // IDLE and DONE share run control; stop beats start.
                        if (stop_i) begin
                            r_ctrl  <= CTRL_IDLE;
                            r_state <= INIT_STATE;
                            r_out   <= '0;
                        end else if (start_i) begin
                            r_ctrl  <= CTRL_RUN;
                            r_state <= INIT_STATE;
                        end
                    end
                endcase
            end
        end
    end

    iob_pfsm_timed_dwell #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cke_i      (cke_i),
        .load_i     (w_start || w_trans),
        .load_val_i (w_dwell_val),
        .dec_i      (w_running && !stop_i),
        .evt_clr_i  (w_start),
        .evt_inc_i  (w_trans),
        .zero_o     (w_dwell_zero),
        .evt_cnt_o  (trans_cnt_o)
    );

    assign cfg_if.cfg_ready_o = w_cfg_ready;
    assign busy_o             = w_running;
    assign done_o             = r_done;
    assign state_o            = r_state;
    assign output_o           = r_out;

endmodule

// File: tb/tb_iob_pfsm_timed.sv
// Directed self-checking bench for iob_pfsm_timed with INPUT_W=2, STATE_W=3,
// OUTPUT_W=8, CNT_W=8.
module tb_iob_pfsm_timed;
    import iob_pfsm_timed_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       cke_i = 1'b1;
    logic       start_i = 1'b0;
    logic       stop_i = 1'b0;
    logic [1:0] input_i = 2'd0;
    logic       busy_o;
    logic       done_o;
    logic [2:0] state_o;
    logic [7:0] output_o;
    logic [7:0] trans_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    iob_pfsm_timed_if #(.INPUT_W(2), .STATE_W(3), .OUTPUT_W(8), .CNT_W(8)) cfg_if ();

    iob_pfsm_timed #(
        .INPUT_W(2), .STATE_W(3), .OUTPUT_W(8), .CNT_W(8)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cke_i       (cke_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .input_i     (input_i),
        .cfg_if      (cfg_if),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .state_o     (state_o),
        .output_o    (output_o),
        .trans_cnt_o (trans_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic cfg_write(input logic sel, input logic [4:0] addr, input logic [10:0] data);
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_sel_i   = sel;
        cfg_if.cfg_addr_i  = addr;
        cfg_if.cfg_wdata_i = data;
        tick(1);
        cfg_if.cfg_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick(2);
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0h want 0", busy_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0h want 0", done_o); end
        n_cmp++; if (output_o !== 8'h00) begin n_err++; $display("FAIL reset_output: got %0h want 0", output_o); end
        n_cmp++; if (state_o !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0h want 0", state_o); end
        n_cmp++; if (trans_cnt_o !== 8'd0) begin n_err++; $display("FAIL reset_trans: got %0h want 0", trans_cnt_o); end
        n_cmp++; if (cfg_if.cfg_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0h want 1", cfg_if.cfg_ready_o); end
        rst_i = 1'b0;
    endtask

    task automatic program_tables();
        for (int i = 0; i < 4; i++) begin
            cfg_write(CFG_SEL_LUT, {3'd0, 2'(i)}, {3'd1, 8'hA5});
            cfg_write(CFG_SEL_LUT, {3'd1, 2'(i)}, {3'd2, 8'h5A});
            cfg_write(CFG_SEL_LUT, {3'd2, 2'(i)}, (i == 3) ? {3'd7, 8'hFF} : {3'd2, 8'h00});
        end
        cfg_write(CFG_SEL_DWELL, 5'd1, 11'd3);
    endtask

    task automatic test_basic();
        input_i = 2'd0;
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL basic_busy_e0: got %0h want 1", busy_o); end
        n_cmp++; if (state_o !== 3'd0) begin n_err++; $display("FAIL basic_state_e0: got %0h want 0", state_o); end
        n_cmp++; if (output_o !== 8'h00) begin n_err++; $display("FAIL basic_out_e0: got %0h want 0", output_o); end
        tick(1);
        n_cmp++; if (state_o !== 3'd1) begin n_err++; $display("FAIL basic_state_e1: got %0h want 1", state_o); end
        n_cmp++; if (output_o !== 8'hA5) begin n_err++; $display("FAIL basic_out_e1: got %0h want a5", output_o); end
        n_cmp++; if (trans_cnt_o !== 8'd1) begin n_err++; $display("FAIL basic_trans_e1: got %0h want 1", trans_cnt_o); end
        for (int c = 2; c <= 4; c++) begin
            tick(1);
            n_cmp++; if (state_o !== 3'd1) begin n_err++; $display("FAIL basic_dwell_e%0d: got %0h want 1", c, state_o); end
        end
        tick(1);
        n_cmp++; if (state_o !== 3'd2) begin n_err++; $display("FAIL basic_state_e5: got %0h want 2", state_o); end
        n_cmp++; if (output_o !== 8'h5A) begin n_err++; $display("FAIL basic_out_e5: got %0h want 5a", output_o); end
        n_cmp++; if (trans_cnt_o !== 8'd2) begin n_err++; $display("FAIL basic_trans_e5: got %0h want 2", trans_cnt_o); end
    endtask

    task automatic test_halt();
        for (int c = 0; c < 5; c++) begin
            tick(1);
            n_cmp++; if (state_o !== 3'd2) begin n_err++; $display("FAIL halt_loop_state%0d: got %0h want 2", c, state_o); end
            n_cmp++; if (trans_cnt_o !== 8'(3 + c)) begin n_err++; $display("FAIL halt_loop_trans%0d: got %0d want %0d", c, trans_cnt_o, 3 + c); end
        end
        n_cmp++; if (output_o !== 8'h00) begin n_err++; $display("FAIL halt_loop_out: got %0h want 0", output_o); end
        input_i = 2'd3;
        tick(1);
        input_i = 2'd0;
        n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL halt_done: got %0h want 1", done_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL halt_busy: got %0h want 0", busy_o); end
        n_cmp++; if (state_o !== 3'd7) begin n_err++; $display("FAIL halt_state: got %0h want 7", state_o); end
        n_cmp++; if (output_o !== 8'hFF) begin n_err++; $display("FAIL halt_out: got %0h want ff", output_o); end
        n_cmp++; if (trans_cnt_o !== 8'd8) begin n_err++; $display("FAIL halt_trans: got %0d want 8", trans_cnt_o); end
        n_cmp++; if (cfg_if.cfg_ready_o !== 1'b1) begin n_err++; $display("FAIL halt_ready: got %0h want 1", cfg_if.cfg_ready_o); end
        tick(1);
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL halt_done_pulse: got %0h want 0", done_o); end
        n_cmp++; if (output_o !== 8'hFF) begin n_err++; $display("FAIL halt_out_hold: got %0h want ff", output_o); end
        n_cmp++; if (state_o !== 3'd7) begin n_err++; $display("FAIL halt_state_hold: got %0h want 7", state_o); end
    endtask

    task automatic test_abort();
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        n_cmp++; if (output_o !== 8'hFF) begin n_err++; $display("FAIL abort_restart_out: got %0h want ff", output_o); end
        n_cmp++; if (trans_cnt_o !== 8'd0) begin n_err++; $display("FAIL abort_restart_trans: got %0d want 0", trans_cnt_o); end
        tick(2);
        n_cmp++; if (state_o !== 3'd1) begin n_err++; $display("FAIL abort_pre_state: got %0h want 1", state_o); end
        stop_i = 1'b1;
        tick(1);
        stop_i = 1'b0;
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %0h want 0", busy_o); end
        n_cmp++; if (state_o !== 3'd0) begin n_err++; $display("FAIL abort_state: got %0h want 0", state_o); end
        n_cmp++; if (output_o !== 8'h00) begin n_err++; $display("FAIL abort_out: got %0h want 0", output_o); end
        start_i = 1'b1;
        stop_i  = 1'b1;
        tick(1);
        start_i = 1'b0;
        stop_i  = 1'b0;
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL abort_both_busy: got %0h want 0", busy_o); end
        tick(1);
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL abort_both_idle: got %0h want 0", busy_o); end
        n_cmp++; if (cfg_if.cfg_ready_o !== 1'b1) begin n_err++; $display("FAIL abort_ready: got %0h want 1", cfg_if.cfg_ready_o); end
    endtask

    task automatic test_lockout();
        input_i = 2'd0;
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        n_cmp++; if (cfg_if.cfg_ready_o !== 1'b0) begin n_err++; $display("FAIL lock_ready: got %0h want 0", cfg_if.cfg_ready_o); end
        cfg_write(CFG_SEL_LUT, 5'd0, {3'd3, 8'h33});
        n_cmp++; if (state_o !== 3'd1) begin n_err++; $display("FAIL lock_run_state: got %0h want 1", state_o); end
        input_i = 2'd3;
        tick(4);
        n_cmp++; if (state_o !== 3'd2) begin n_err++; $display("FAIL lock_s2: got %0h want 2", state_o); end
        tick(1);
        n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL lock_done: got %0h want 1", done_o); end
        input_i = 2'd0;
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL lock_restart_busy: got %0h want 1", busy_o); end
        tick(1);
        n_cmp++; if (state_o !== 3'd1) begin n_err++; $display("FAIL lock_lut0_state: got %0h want 1", state_o); end
        n_cmp++; if (output_o !== 8'hA5) begin n_err++; $display("FAIL lock_lut0_out: got %0h want a5", output_o); end
        stop_i = 1'b1;
        tick(1);
        stop_i = 1'b0;
        n_cmp++; if (output_o !== 8'h00) begin n_err++; $display("FAIL lock_stop_out: got %0h want 0", output_o); end
    endtask

    task automatic test_saturation();
        cfg_write(CFG_SEL_LUT, 5'd0, {3'd0, 8'h3C});
        input_i = 2'd0;
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        tick(100);
        n_cmp++; if (trans_cnt_o !== 8'd100) begin n_err++; $display("FAIL sat_trans100: got %0d want 100", trans_cnt_o); end
        n_cmp++; if (output_o !== 8'h3C) begin n_err++; $display("FAIL sat_out: got %0h want 3c", output_o); end
        cke_i  = 1'b0;
        stop_i = 1'b1;
        rst_i  = 1'b1;
        tick(10);
        stop_i = 1'b0;
        rst_i  = 1'b0;
        n_cmp++; if (trans_cnt_o !== 8'd100) begin n_err++; $display("FAIL freeze_trans: got %0d want 100", trans_cnt_o); end
        n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL freeze_busy: got %0h want 1", busy_o); end
        n_cmp++; if (output_o !== 8'h3C) begin n_err++; $display("FAIL freeze_out: got %0h want 3c", output_o); end
        n_cmp++; if (state_o !== 3'd0) begin n_err++; $display("FAIL freeze_state: got %0h want 0", state_o); end
        cke_i = 1'b1;
        tick(154);
        n_cmp++; if (trans_cnt_o !== 8'd254) begin n_err++; $display("FAIL sat_trans254: got %0d want 254", trans_cnt_o); end
        tick(1);
        n_cmp++; if (trans_cnt_o !== 8'd255) begin n_err++; $display("FAIL sat_trans255: got %0d want 255", trans_cnt_o); end
        tick(45);
        n_cmp++; if (trans_cnt_o !== 8'd255) begin n_err++; $display("FAIL sat_stick: got %0d want 255", trans_cnt_o); end
        n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL sat_busy: got %0h want 1", busy_o); end
        stop_i = 1'b1;
        tick(1);
        stop_i = 1'b0;
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL sat_stop_busy: got %0h want 0", busy_o); end
    endtask

    initial begin
        cfg_if.cfg_valid_i = 1'b0;
        cfg_if.cfg_sel_i   = 1'b0;
        cfg_if.cfg_addr_i  = '0;
        cfg_if.cfg_wdata_i = '0;
        test_reset();
        program_tables();
        test_basic();
        test_halt();
        test_abort();
        test_lockout();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/iob_pfsm_timed.md
Name: iob_pfsm_timed

Overview:
Programmable FSM with per-state minimum dwell timing, run control and halt detection.
- Transitions, outputs and dwell times come from software-loaded tables.
- Sits beside the existing programmable FSM in the PFSM core and is driven by the same CSR layer through a simple config write port.
- Adds over a plain LUT-based FSM: start/stop/done sequencing, dwell counting, registered outputs and a transition counter.

Parameters:
INPUT_W, 2, width of external condition inputs
STATE_W, 3, state width; state {STATE_W{1'b1}} is the halt state
OUTPUT_W, 8, width of programmable outputs
CNT_W, 16, dwell counter and transition counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cke_i  in  1  clock enable; when low all registers hold
start_i  in  1  start request (level sampled)
stop_i  in  1  abort request
input_i  in  INPUT_W  condition inputs, sampled unregistered
cfg_valid_i  in  1  config write strobe
cfg_sel_i  in  1  0 = transition LUT, 1 = dwell table
cfg_addr_i  in  STATE_W+INPUT_W  LUT address {state,input}; dwell table uses the low STATE_W bits
cfg_wdata_i  in  max(STATE_W+OUTPUT_W,CNT_W)  LUT word {next_state,outputs}, or dwell value in the low CNT_W bits
cfg_ready_o  out  1  high when idle; writes accepted only when high
busy_o  out  1  FSM running
done_o  out  1  one-cycle pulse on halt entry
state_o  out  STATE_W  current programmable state
output_o  out  OUTPUT_W  registered programmable outputs
trans_cnt_o  out  CNT_W  transitions since last start, saturating

Behaviour:
- Reset (rst_i=1 at clk edge with cke_i=1):
  - control state IDLE; state_o, output_o, trans_cnt_o = 0; busy_o, done_o = 0; cfg_ready_o = 1.
  - Both tables cleared to zero.
- Control FSM states IDLE, RUN, DONE.
- IDLE:
  - cfg_ready_o = 1; a write with cfg_valid_i=1 lands at that edge.
  - start_i=1 and stop_i=0 -> RUN next cycle: state=0, dwell_cnt=dwell[0], trans_cnt=0, output_o unchanged.
  - start_i and stop_i both high -> stop wins, remain IDLE.
- RUN:
  - busy_o = 1; cfg_ready_o = 0; cfg writes are ignored (no side effect).
  - stop_i=1 -> IDLE next cycle: state_o=0, output_o=0. Priority over any transition that cycle.
  - dwell_cnt != 0 -> decrement and hold state.
  - dwell_cnt == 0 -> read LUT[{state,input_i}] combinationally, then at the edge:
    - state <= next_state; output_o <= outputs; dwell_cnt <= dwell[next_state];
    - trans_cnt += 1, saturating at all-ones.
  - A self-loop counts as a transition and reloads dwell.
  - Dwell value D gives a minimum residence of D+1 cycles.
  - next_state == all-ones -> DONE instead of RUN; done_o = 1 for exactly that following cycle.
- DONE:
  - busy_o = 0; cfg_ready_o = 1.
  - output_o, state_o and trans_cnt_o hold.
  - start_i restarts exactly as from IDLE; stop_i -> IDLE with output_o cleared.
- Latency: start edge to first possible transition = 1 + dwell[0] cycles; outputs update on the transition edge (registered).
- cke_i=0 freezes all state, including counters and the done pulse; rst_i is honoured only when cke_i=1.
- Width rules:
  - LUT word: next_state in the MSBs, outputs in the LSBs.
  - The unused high bits of cfg_wdata_i are ignored.
  - Counters wrap nowhere: dwell counts down to 0; trans_cnt saturates.

Decomposition:
- iob_pfsm_timed_conf.vh holds:
  - control state encodings (IDLE=0, RUN=1, DONE=2);
  - the HALT_STATE and LUT_W=STATE_W+OUTPUT_W localparams;
  - the cfg_sel encodings.
- Tables reuse the existing iob_regfile_sp (two instances).
- One natural sub-module: iob_pfsm_timed_dwell.
  - Loadable down-counter with zero flag and saturating event counter.
  - Parameter CNT_W.

Test Plan:
(All with INPUT_W=2, STATE_W=3, OUTPUT_W=8, CNT_W=8.)
- Reset: hold rst_i 2 cycles -> busy_o=0, done_o=0, output_o=0x00, state_o=0, trans_cnt_o=0, cfg_ready_o=1.
- Basic sequence: program LUT s0->s1 out 0xA5, s1->s2 out 0x5A, dwell[1]=3; start at edge E0 -> output_o=0xA5/state 1 after E1, state 1 for exactly 4 cycles, state 2/0x5A after E5.
- Halt: LUT s2,in=3 -> 7 out 0xFF, otherwise s2 self-loop 0x00.
  - Hold in=0 for 5 cycles: state stays 2, trans_cnt increments each cycle.
  - Drive in=3: done_o single pulse, busy_o=0, output_o=0xFF holds, cfg_ready_o=1.
- Abort: stop_i during state-1 dwell -> next cycle busy_o=0, state_o=0, output_o=0x00. Start and stop together in IDLE -> stays IDLE.
- Config lockout: cfg write to LUT[0] while busy -> ignored. After done, the original LUT[0] behaviour is observed on restart.
- Saturation: s0 self-loop with dwell 0, run 300 cycles -> trans_cnt_o sticks at 0xFF. cke_i low for 10 cycles mid-run -> all outputs frozen.
